vend_credit_ctrl: RTL and testbench
===================================

// Module: vend_credit_ctrl
// PURPOSE
//   Parametrised credit controller for the vending machine: accumulates coin value,
//   debits item prices only when credit covers them, and returns change one coin per cycle.
//   Rejects coins that would overflow the credit register.
//   Sits between the coin/selection input pulses and the dispenser and change-hopper drivers.
// PARAMETERS
//   CREDIT_W   8    width of the credit register, in bits
//   CREDIT_MAX 255  credit ceiling in cents; must be < 2**CREDIT_W
//   PRICE_A    75   apple price in cents (must be <= CREDIT_MAX; same for all prices)
//   PRICE_B    20   banana price in cents
//   PRICE_C    30   carrot price in cents
//   PRICE_D    40   date price in cents
// PORTS
//   clk          in   1         system clock; all state changes on its rising edge
//   reset        in   1         asynchronous, active-high reset
//   penny        in   1         1-cent coin pulse, one cycle per coin
//   nickel       in   1         5-cent coin pulse
//   dime         in   1         10-cent coin pulse
//   quarter      in   1         25-cent coin pulse
//   apple        in   1         select item A, one-cycle pulse
//   banana       in   1         select item B
//   carrot       in   1         select item C
//   date         in   1         select item D
//   return_req   in   1         request return of all remaining credit as change
//   credit       out  CREDIT_W  current credit in cents
//   vend         out  4         one-hot dispense pulse {date,carrot,banana,apple}
//   deny         out  1         selection refused (insufficient credit or busy)
//   coin_reject  out  1         coin refused and routed to the return chute
//   change_coin  out  4         one-hot change pulse {quarter,dime,nickel,penny}
//   busy         out  1         high in VEND and CHANGE states
// BEHAVIOUR
//   Reset:
//   - Forces state IDLE, credit=0; vend, deny, coin_reject, change_coin = 0; busy = 0.
//   Registering and latency:
//   - All outputs are registered.
//   - An input sampled at edge N produces its effect on the outputs after edge N.
//   - Pulse outputs are high for exactly one cycle.
//   IDLE state, one event per cycle; priority: return_req > coins > selections.
//   - return_req with credit>0 -> CHANGE.
//   - return_req with credit==0 -> no-op.
//   - Coins: priority penny > nickel > dime > quarter.
//     - Accept the highest-priority coin: credit += value.
//     - coin_reject pulses if any other coin was high in the same cycle.
//     - coin_reject also pulses if credit+value > CREDIT_MAX; credit is then unchanged.
//     - Compute the sum at CREDIT_W+1 bits; no wrap-around.
//   - Selection with no coin: priority apple > banana > carrot > date.
//     - If credit >= price: credit -= price, the matching vend bit pulses, go to VEND.
//     - Else deny pulses and credit is unchanged.
//     - Any additional selection bits high in the same cycle are ignored.
//   - A selection present together with an accepted coin or return_req -> deny pulses.
//   VEND state:
//   - Lasts exactly one cycle, then returns to IDLE.
//   - Any coin -> coin_reject.
//   - Any selection -> deny.
//   - return_req is ignored (it must be re-asserted).
//   CHANGE state:
//   - Each cycle, greedy selection of one coin:
//     - quarter if credit >= 25;
//     - else dime if credit >= 10;
//     - else nickel if credit >= 5;
//     - else penny.
//   - The chosen change_coin bit pulses and credit -= that value on the same edge.
//   - The edge that brings credit to 0 also moves the state to IDLE (no extra cycle).
//   - Coins -> coin_reject.
//   - Selections -> deny.
//   - return_req is ignored.
//   Reset mid-operation:
//   - Aborts VEND/CHANGE immediately.
//   - Residual credit is discarded; no further pulses are issued.
//   busy = (state != IDLE), registered.
// TESTING
//   1. Reset, then quarter x3 -> credit 25, 50, 75; apple -> vend=0001 one cycle, credit 0, busy one cycle.
//   2. credit 10, carrot -> deny one cycle, credit stays 10, vend stays 0000.
//   3. credit 245, quarter -> coin_reject, credit 245; penny x10 -> credit 255; penny -> coin_reject.
//   4. credit 41, return_req -> change_coin 1000, 0100, 0010, 0001 on consecutive cycles; credit 16, 6, 1, 0; IDLE.
//   5. nickel+dime same cycle from credit 0 -> credit 5, coin_reject one cycle; quarter during CHANGE -> coin_reject.
//   6. Assert reset asynchronously mid-CHANGE (credit 30) -> credit 0, change_coin 0 before the next edge, state IDLE.

Source files
------------

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit accumulator with priced vending and greedy one-coin-per-cycle change return
module vend_credit_ctrl #(
   parameter int CREDIT_W   = 8,
   parameter int CREDIT_MAX = 255,
   parameter int PRICE_A    = 75,
   parameter int PRICE_B    = 20,
   parameter int PRICE_C    = 30,
   parameter int PRICE_D    = 40
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                penny,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic                apple,
   input  logic                banana,
   input  logic                carrot,
   input  logic                date,
   input  logic                return_req,
   output logic [CREDIT_W-1:0] credit,
   output logic [3:0]          vend,
   output logic                deny,
   output logic                coin_reject,
   output logic [3:0]          change_coin,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
   state_t state, state_n;
   logic [CREDIT_W-1:0] credit_n, coin_val, price, chg_val;
   logic [CREDIT_W:0]   sum;
   logic [3:0]          coins, sels, sel_hot, chg_hot, vend_n, change_n;
   logic                multi_coin, overflow, deny_n, reject_n;
   assign coins      = {quarter, dime, nickel, penny};
   assign sels       = {date, carrot, banana, apple};
   assign multi_coin = (coins & (coins - 4'd1)) != 4'd0;
   assign sel_hot    = sels & (~sels + 4'd1);
   assign coin_val   = penny ? CREDIT_W'(1) : nickel ? CREDIT_W'(5) : dime ? CREDIT_W'(10) : CREDIT_W'(25);
   assign price      = apple ? CREDIT_W'(PRICE_A) : banana ? CREDIT_W'(PRICE_B) :
                       carrot ? CREDIT_W'(PRICE_C) : CREDIT_W'(PRICE_D);
   assign sum        = {1'b0, credit} + {1'b0, coin_val};
   assign overflow   = sum > (CREDIT_W+1)'(CREDIT_MAX);
   assign chg_val    = credit >= CREDIT_W'(25) ? CREDIT_W'(25) : credit >= CREDIT_W'(10) ? CREDIT_W'(10) :
                       credit >= CREDIT_W'(5) ? CREDIT_W'(5) : CREDIT_W'(1);
   assign chg_hot    = credit >= CREDIT_W'(25) ? 4'b1000 : credit >= CREDIT_W'(10) ? 4'b0100 :
                       credit >= CREDIT_W'(5) ? 4'b0010 : 4'b0001;
   // next state and next registered outputs; coins arriving with return_req are not accepted, so they are rejected
   always_comb begin
      state_n  = state;
      credit_n = credit;
      vend_n   = 4'd0;
      change_n = 4'd0;
      deny_n   = 1'b0;
      reject_n = 1'b0;
      case (state)
         IDLE: begin
            if (return_req) begin
               state_n  = credit != '0 ? CHANGE : IDLE;
               reject_n = |coins;
               deny_n   = |sels;
            end else if (|coins) begin
               reject_n = multi_coin | overflow;
               credit_n = overflow ? credit : sum[CREDIT_W-1:0];
               deny_n   = |sels;
            end else if (|sels) begin
               if (credit >= price) begin
                  credit_n = credit - price;
                  vend_n   = sel_hot;
                  state_n  = VEND;
               end else
                  deny_n = 1'b1;
            end
         end
         VEND: begin
            state_n  = IDLE;
            reject_n = |coins;
            deny_n   = |sels;
         end
         CHANGE: begin
            reject_n = |coins;
            deny_n   = |sels;
            if (credit == '0)
               state_n = IDLE;
            else begin
               credit_n = credit - chg_val;
               change_n = chg_hot;
               state_n  = credit == chg_val ? IDLE : CHANGE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   // state and output registers, cleared immediately by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         vend        <= 4'd0;
         deny        <= 1'b0;
         coin_reject <= 1'b0;
         change_coin <= 4'd0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         vend        <= vend_n;
         deny        <= deny_n;
         coin_reject <= reject_n;
         change_coin <= change_n;
         busy        <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed and randomized checks of vend_credit_ctrl against a behavioural model
module tb_vend_credit_ctrl;
   logic       clk = 1'b0, reset = 1'b1;
   logic       penny = 0, nickel = 0, dime = 0, quarter = 0;
   logic       apple = 0, banana = 0, carrot = 0, date = 0, return_req = 0;
   logic [7:0] credit;
   logic [3:0] vend, change_coin;
   logic       deny, coin_reject, busy;
   int errors = 0, checks = 0;
   int m_credit = 0, m_mode = 0;
   int m_vend = 0, m_deny = 0, m_rej = 0, m_chg = 0;
   int coin_value[4] = '{1, 5, 10, 25};
   int item_price[4] = '{75, 20, 30, 40};
   vend_credit_ctrl dut (
      .clk(clk), .reset(reset), .penny(penny), .nickel(nickel), .dime(dime), .quarter(quarter),
      .apple(apple), .banana(banana), .carrot(carrot), .date(date), .return_req(return_req),
      .credit(credit), .vend(vend), .deny(deny), .coin_reject(coin_reject),
      .change_coin(change_coin), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_credit = 0; m_mode = 0; m_vend = 0; m_deny = 0; m_rej = 0; m_chg = 0;
   endtask
   // mode: 0 idle, 1 dispensing, 2 paying change
   task automatic model_step(input logic [3:0] c, input logic [3:0] s, input logic r);
      int n;
      m_vend = 0; m_deny = 0; m_rej = 0; m_chg = 0;
      n = $countones(c);
      if (m_mode == 0) begin
         if (r) begin
            if (m_credit > 0) m_mode = 2;
            m_rej = int'(n > 0); m_deny = int'(s != 0);
         end else if (n > 0) begin
            for (int i = 0; i < 4; i++)
               if (c[i]) begin
                  if (m_credit + coin_value[i] > 255) m_rej = 1;
                  else m_credit += coin_value[i];
                  break;
               end
            if (n > 1) m_rej = 1;
            m_deny = int'(s != 0);
         end else if (s != 0) begin
            for (int j = 0; j < 4; j++)
               if (s[j]) begin
                  if (m_credit >= item_price[j]) begin
                     m_credit -= item_price[j]; m_vend = 1 << j; m_mode = 1;
                  end else m_deny = 1;
                  break;
               end
         end
      end else if (m_mode == 1) begin
         m_mode = 0; m_rej = int'(n > 0); m_deny = int'(s != 0);
      end else begin
         m_rej = int'(n > 0); m_deny = int'(s != 0);
         for (int i = 3; i >= 0; i--)
            if (m_credit >= coin_value[i]) begin
               m_credit -= coin_value[i]; m_chg = 1 << i;
               break;
            end
         if (m_credit == 0) m_mode = 0;
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".credit"}, int'(credit), m_credit);
      check({tag, ".vend"}, int'(vend), m_vend);
      check({tag, ".deny"}, int'(deny), m_deny);
      check({tag, ".reject"}, int'(coin_reject), m_rej);
      check({tag, ".change"}, int'(change_coin), m_chg);
      check({tag, ".busy"}, int'(busy), int'(m_mode != 0));
   endtask
   task automatic step(input string tag, input logic [3:0] c, input logic [3:0] s, input logic r);
      {quarter, dime, nickel, penny} = c;
      {date, carrot, banana, apple} = s;
      return_req = r;
      @(posedge clk);
      model_step(c, s, r);
      #1 check_all(tag);
   endtask
   task automatic idle(input string tag);
      step(tag, 4'd0, 4'd0, 1'b0);
   endtask
   task automatic sync_reset();
      reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
      check_all("reset");
   endtask
   task automatic async_reset(input string tag);
      #3 reset = 1'b1;
      #1 model_reset();
      check_all(tag);
      #1 reset = 1'b0;
   endtask
   initial begin
      sync_reset();
      for (int i = 0; i < 3; i++) step("t1_coin", 4'b1000, 4'd0, 1'b0);
      check("t1_credit75", int'(credit), 75);
      step("t1_apple", 4'd0, 4'b0001, 1'b0);
      check("t1_vend", int'(vend), 1);
      idle("t1_after");
      check("t1_busy_drop", int'(busy), 0);
      sync_reset();
      step("t2_dime", 4'b0100, 4'd0, 1'b0);
      step("t2_carrot", 4'd0, 4'b0100, 1'b0);
      check("t2_deny", int'(deny), 1);
      check("t2_credit", int'(credit), 10);
      idle("t2_after");
      sync_reset();
      for (int i = 0; i < 9; i++) step("t3_q", 4'b1000, 4'd0, 1'b0);
      step("t3_d", 4'b0100, 4'd0, 1'b0);
      step("t3_d", 4'b0100, 4'd0, 1'b0);
      check("t3_credit245", int'(credit), 245);
      step("t3_qovf", 4'b1000, 4'd0, 1'b0);
      check("t3_reject", int'(coin_reject), 1);
      for (int i = 0; i < 10; i++) step("t3_p", 4'b0001, 4'd0, 1'b0);
      check("t3_credit255", int'(credit), 255);
      step("t3_povf", 4'b0001, 4'd0, 1'b0);
      check("t3_reject255", int'(coin_reject), 1);
      sync_reset();
      step("t4_q", 4'b1000, 4'd0, 1'b0);
      step("t4_d", 4'b0100, 4'd0, 1'b0);
      step("t4_n", 4'b0010, 4'd0, 1'b0);
      step("t4_p", 4'b0001, 4'd0, 1'b0);
      step("t4_ret", 4'd0, 4'd0, 1'b1);
      for (int i = 0; i < 4; i++) idle("t4_chg");
      check("t4_last", int'(change_coin), 1);
      check("t4_zero", int'(credit), 0);
      idle("t4_idle");
      sync_reset();
      step("t5_nd", 4'b0110, 4'd0, 1'b0);
      check("t5_credit5", int'(credit), 5);
      step("t5_ret", 4'd0, 4'd0, 1'b1);
      step("t5_qchg", 4'b1000, 4'd0, 1'b0);
      check("t5_reject", int'(coin_reject), 1);
      idle("t5_after");
      sync_reset();
      step("t6_q", 4'b1000, 4'd0, 1'b0);
      step("t6_q", 4'b1000, 4'd0, 1'b0);
      step("t6_n", 4'b0010, 4'd0, 1'b0);
      step("t6_ret", 4'd0, 4'd0, 1'b1);
      idle("t6_chg");
      check("t6_credit30", int'(credit), 30);
      async_reset("t6_async");
      idle("t6_after");
      for (int k = 0; k < 4000; k++) begin
         logic [3:0] c, s;
         for (int b = 0; b < 4; b++) begin
            c[b] = $urandom_range(0, 5) == 0;
            s[b] = $urandom_range(0, 11) == 0;
         end
         step("rnd", c, s, $urandom_range(0, 39) == 0);
         if ($urandom_range(0, 499) == 0) async_reset("rnd_async");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
